// File: rtl/csr_file_if.sv
// Writeback-stage CSR write port and execute-stage CSR read port, bundled as one bus.
// Member names carry the direction as seen from the CSR file (the slave side).
`ifndef XLEN
`define XLEN 32
`endif

interface csr_file_if #(
  parameter int unsigned Xlen = `XLEN
) ();

  // Write port (writeback stage)
  logic            csr_we_i;
  logic [11:0]     csr_addr_i;
  logic [Xlen-1:0] csr_data_i;

  // Read port (execute stage)
  logic [11:0]     rd_addr_i;
  logic [Xlen-1:0] rd_data_o;
  logic            illegal_o;

  modport slave (
    input  csr_we_i,
    input  csr_addr_i,
    input  csr_data_i,
    input  rd_addr_i,
    output rd_data_o,
    output illegal_o
  );

  modport master (
    output csr_we_i,
    output csr_addr_i,
    output csr_data_i,
    output rd_addr_i,
    input  rd_data_o,
    input  illegal_o
  );

endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap/mret state, trap vector, scratch, and the cycle/instret
// counters, with a combinational read port that forwards a same-cycle write.
`ifndef XLEN
`define XLEN 32
`endif

module csr_file (
  input  logic              clk_i,
  input  logic              rst_i,
  csr_file_if.slave         bus_if,
  input  logic              trap_i,
  input  logic [`XLEN-1:0]  trap_pc_i,
  input  logic [`XLEN-1:0]  trap_cause_i,
  input  logic [`XLEN-1:0]  trap_val_i,
  input  logic              mret_i,
  input  logic              instret_i,
  output logic [`XLEN-1:0]  mtvec_o,
  output logic [`XLEN-1:0]  mepc_o,
  output logic              mie_o
);

  localparam int unsigned Xlen = `XLEN;

  localparam logic [11:0] AddrMstatus  = 12'h300;
  localparam logic [11:0] AddrMisa     = 12'h301;
  localparam logic [11:0] AddrMie      = 12'h304;
  localparam logic [11:0] AddrMtvec    = 12'h305;
  localparam logic [11:0] AddrMscratch = 12'h340;
  localparam logic [11:0] AddrMepc     = 12'h341;
  localparam logic [11:0] AddrMcause   = 12'h342;
  localparam logic [11:0] AddrMtval    = 12'h343;
  localparam logic [11:0] AddrMip      = 12'h344;
  localparam logic [11:0] AddrMcycle   = 12'hB00;
  localparam logic [11:0] AddrMinstret = 12'hB02;
  localparam logic [11:0] AddrCycle    = 12'hC00;
  localparam logic [11:0] AddrInstret  = 12'hC02;
  localparam logic [11:0] AddrMhartid  = 12'hF14;

  // MXL encodes the native width; only the base integer ISA (I, bit 8) is advertised.
  localparam logic [1:0]      Mxl     = (Xlen == 64) ? 2'd2 : ((Xlen == 128) ? 2'd3 : 2'd1);
  localparam logic [Xlen-1:0] MisaVal = {Mxl, {(Xlen - 2){1'b0}}} | Xlen'(9'h100);

  // mstatus as software sees it: only MIE/MPIE are stored, MPP is hardwired to M-mode.
  function automatic logic [Xlen-1:0] pack_mstatus(input logic mie, input logic mpie);
    logic [Xlen-1:0] v;
    v        = '0;
    v[3]     = mie;
    v[7]     = mpie;
    v[12:11] = 2'b11;
    return v;
  endfunction

  // State
  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [Xlen-1:0] mie_q, mie_d;
  logic [Xlen-1:0] mtvec_q, mtvec_d;
  logic [Xlen-1:0] mscratch_q, mscratch_d;
  logic [Xlen-1:0] mepc_q, mepc_d;
  logic [Xlen-1:0] mcause_q, mcause_d;
  logic [Xlen-1:0] mtval_q, mtval_d;
  logic [Xlen-1:0] mcycle_q, mcycle_d;
  logic [Xlen-1:0] minstret_q, minstret_d;

  // Write decode
  logic            wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc;
  logic            wr_mcause, wr_mtval, wr_mcycle, wr_minstret;
  logic [Xlen-1:0] wdata;
  logic [Xlen-1:0] wdata_aligned;
  logic            do_mret;

  // Per-register read views with the same-cycle write already forwarded in
  logic            mstatus_mie_v, mstatus_mpie_v;
  logic [Xlen-1:0] mie_v, mtvec_v, mscratch_v, mepc_v, mcause_v, mtval_v;
  logic [Xlen-1:0] mcycle_v, minstret_v;

  // Decode which writable register, if any, the writeback stage targets this cycle
  always_comb begin
    wdata         = bus_if.csr_data_i;
    wdata_aligned = {bus_if.csr_data_i[Xlen-1:2], 2'b00};
    wr_mstatus    = bus_if.csr_we_i && (bus_if.csr_addr_i == AddrMstatus);
    wr_mie        = bus_if.csr_we_i && (bus_if.csr_addr_i == AddrMie);
    wr_mtvec      = bus_if.csr_we_i && (bus_if.csr_addr_i == AddrMtvec);
    wr_mscratch   = bus_if.csr_we_i && (bus_if.csr_addr_i == AddrMscratch);
    wr_mepc       = bus_if.csr_we_i && (bus_if.csr_addr_i == AddrMepc);
    wr_mcause     = bus_if.csr_we_i && (bus_if.csr_addr_i == AddrMcause);
    wr_mtval      = bus_if.csr_we_i && (bus_if.csr_addr_i == AddrMtval);
    wr_mcycle     = bus_if.csr_we_i && (bus_if.csr_addr_i == AddrMcycle);
    wr_minstret   = bus_if.csr_we_i && (bus_if.csr_addr_i == AddrMinstret);
    // A trap in the same cycle suppresses mret entirely.
    do_mret       = mret_i && !trap_i;
  end

  // Forward a same-cycle software write (masked) to the read port
  always_comb begin
    mstatus_mie_v  = wr_mstatus  ? wdata[3]      : mstatus_mie_q;
    mstatus_mpie_v = wr_mstatus  ? wdata[7]      : mstatus_mpie_q;
    mie_v          = wr_mie      ? wdata         : mie_q;
    mtvec_v        = wr_mtvec    ? wdata_aligned : mtvec_q;
    mscratch_v     = wr_mscratch ? wdata         : mscratch_q;
    mepc_v         = wr_mepc     ? wdata_aligned : mepc_q;
    mcause_v       = wr_mcause   ? wdata         : mcause_q;
    mtval_v        = wr_mtval    ? wdata         : mtval_q;
    mcycle_v       = wr_mcycle   ? wdata         : mcycle_q;
    minstret_v     = wr_minstret ? wdata         : minstret_q;
  end

  // Read mux; unimplemented addresses flag illegal and return zero
  always_comb begin
    bus_if.rd_data_o = '0;
    bus_if.illegal_o = 1'b0;
    unique case (bus_if.rd_addr_i)
      AddrMstatus:  bus_if.rd_data_o = pack_mstatus(mstatus_mie_v, mstatus_mpie_v);
      AddrMisa:     bus_if.rd_data_o = MisaVal;
      AddrMie:      bus_if.rd_data_o = mie_v;
      AddrMtvec:    bus_if.rd_data_o = mtvec_v;
      AddrMscratch: bus_if.rd_data_o = mscratch_v;
      AddrMepc:     bus_if.rd_data_o = mepc_v;
      AddrMcause:   bus_if.rd_data_o = mcause_v;
      AddrMtval:    bus_if.rd_data_o = mtval_v;
      AddrMip:      bus_if.rd_data_o = '0;
      AddrMcycle:   bus_if.rd_data_o = mcycle_v;
      AddrMinstret: bus_if.rd_data_o = minstret_v;
      AddrCycle:    bus_if.rd_data_o = mcycle_v;
      AddrInstret:  bus_if.rd_data_o = minstret_v;
      AddrMhartid:  bus_if.rd_data_o = '0;
      default:      bus_if.illegal_o = 1'b1;
    endcase
  end

  // Next state: software write first, then trap/mret override the registers they own
  always_comb begin
    mstatus_mie_d  = mstatus_mie_v;
    mstatus_mpie_d = mstatus_mpie_v;
    mie_d          = mie_v;
    mtvec_d        = mtvec_v;
    mscratch_d     = mscratch_v;
    mepc_d         = mepc_v;
    mcause_d       = mcause_v;
    mtval_d        = mtval_v;
    // A counter write replaces this cycle's increment rather than adding to it.
    mcycle_d       = wr_mcycle ? wdata : mcycle_q + {{(Xlen - 1){1'b0}}, 1'b1};
    minstret_d     = wr_minstret ? wdata : minstret_q + {{(Xlen - 1){1'b0}}, instret_i};

    if (trap_i) begin
      mepc_d         = {trap_pc_i[Xlen-1:2], 2'b00};
      mcause_d       = trap_cause_i;
      mtval_d        = trap_val_i;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (do_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  // State registers; synchronous reset drops anything arriving in the same cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

  // Registered side outputs to the fetch/interrupt logic
  always_comb begin
    mtvec_o = mtvec_q;
    mepc_o  = mepc_q;
    mie_o   = mstatus_mie_q;
  end

endmodule
